// File: rtl/edge_pkg.sv
// Shared types and default parameter values for the multi-channel edge detector.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned NUM_CH_DEF      = 2;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILTER_LEN_DEF  = 2;
  localparam int unsigned IDLE_CYCLES_DEF = 8;

  function automatic logic rise_en(input edge_mode_e m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  function automatic logic fall_en(input edge_mode_e m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchronizer chain, persistence filter, masked edge pulses and
// idle timer.
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_in,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       d_filt,
  output logic       d_rise,
  output logic       d_fall,
  output logic       idle
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [IW-1:0]          icnt_q, icnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   idle_q, idle_d;
  logic                   sync_out;
  logic                   accept;
  edge_mode_e             mode_e;

  always_comb begin
    mode_e   = edge_mode_e'(mode);
    sync_out = sync_q[SYNC_STAGES-1];
    accept   = (sync_out != filt_q) && (fcnt_q == FILT_LAST);
    filt_d   = accept ? sync_out : filt_q;

    // clear only resets counting; an acceptance on the same edge still lands
    if ((sync_out == filt_q) || accept || clear) fcnt_d = '0;
    else                                         fcnt_d = fcnt_q + FW'(1);

    rise_d = accept &&  sync_out && rise_en(mode_e);
    fall_d = accept && !sync_out && fall_en(mode_e);

    if (accept || clear)         icnt_d = '0;
    else if (icnt_q != IDLE_MAX) icnt_d = icnt_q + IW'(1);
    else                         icnt_d = icnt_q;
    idle_d = (icnt_d == IDLE_MAX);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      filt_q <= RST_VAL;
      fcnt_q <= '0;
      icnt_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      icnt_q <= icnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      idle_q <= idle_d;
    end
  end

  assign d_filt = filt_q;
  assign d_rise = rise_q;
  assign d_fall = fall_q;
  assign idle   = idle_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronized, glitch-filtered edge detector with per-channel
// edge select and idle indication.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned       NUM_CH      = NUM_CH_DEF,
  parameter int unsigned       SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned       FILTER_LEN  = FILTER_LEN_DEF,
  parameter int unsigned       IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter logic [NUM_CH-1:0] RST_VAL     = '1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_CH-1:0]     d_in,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic                  clear,
  output logic [NUM_CH-1:0]     d_filt,
  output logic [NUM_CH-1:0]     d_rise,
  output logic [NUM_CH-1:0]     d_fall,
  output logic [NUM_CH-1:0]     d_edge,
  output logic [NUM_CH-1:0]     idle,
  output logic                  any_edge
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_CYCLES (IDLE_CYCLES),
      .RST_VAL     (RST_VAL[i])
    ) u_chan (
      .clk    (clk),
      .n_rst  (n_rst),
      .d_in   (d_in[i]),
      .mode   (mode[2*i +: 2]),
      .clear  (clear),
      .d_filt (d_filt[i]),
      .d_rise (d_rise[i]),
      .d_fall (d_fall[i]),
      .idle   (idle[i])
    );
  end

  // Derived from registered pulses only, so nothing here is combinational from d_in
  always_comb begin
    d_edge   = d_rise | d_fall;
    any_edge = |d_edge;
  end

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent input channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel (>=2).
REQ-003 Parameter FILTER_LEN, default 2: consecutive cycles a new level must persist before acceptance (>=1).
REQ-004 Parameter IDLE_CYCLES, default 8: transition-free cycles before the idle flag asserts (>=1).
REQ-005 Parameter RST_VAL, default all ones: per-channel reset line level, NUM_CH bits.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and n_rst.
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 n_rst  input  1  asynchronous active-low reset.
REQ-009 d_in  input  NUM_CH  raw asynchronous line inputs.
REQ-010 mode  input  2*NUM_CH  per-channel edge select: 00 off, 01 rise, 10 fall, 11 both.
REQ-011 clear  input  1  synchronous clear of filter and idle counters.
REQ-012 d_filt  output  NUM_CH  synchronized, filtered line level.
REQ-013 d_rise  output  NUM_CH  one-cycle pulse on accepted 0->1, masked by mode.
REQ-014 d_fall  output  NUM_CH  one-cycle pulse on accepted 1->0, masked by mode.
REQ-015 d_edge  output  NUM_CH  d_rise | d_fall per channel.
REQ-016 idle  output  NUM_CH  high while channel has had no accepted transition for IDLE_CYCLES cycles.
REQ-017 any_edge  output  1  OR-reduction of d_edge.

Function
REQ-018 Each d_in bit SHALL pass through a SYNC_STAGES-deep flop chain; chain output is sync_out.
REQ-019 Filter counter: sync_out == d_filt -> cnt <= 0; sync_out != d_filt and cnt < FILTER_LEN-1 -> cnt++; sync_out != d_filt and cnt == FILTER_LEN-1 -> d_filt <= sync_out, cnt <= 0 ("accepted transition").
REQ-020 Pulses SHALL be registered on the same edge as the accepted transition: d_rise if new level 1 and mode in {01,11}; d_fall if new level 0 and mode in {10,11}; else 0 next cycle.
REQ-021 Latency: d_in level stable before edge 1 SHALL appear on d_filt and pulse outputs after edge SYNC_STAGES+FILTER_LEN.
REQ-022 Glitches shorter than FILTER_LEN sync cycles SHALL produce no d_filt change and no pulse.
REQ-023 FILTER_LEN=1: every sync_out change accepted; toggling every cycle yields back-to-back pulses.
REQ-024 mode SHALL be sampled at the accepting edge; mode changes never alter d_filt or counters.
REQ-025 Idle counter: zeroed on any accepted transition (regardless of mode), else increments, saturating at IDLE_CYCLES; idle = (counter == IDLE_CYCLES), registered.
REQ-026 clear SHALL zero filter and idle counters, deassert idle next cycle, leave d_filt and sync chain unchanged; clear coincident with an acceptance still updates d_filt and emits the pulse.
REQ-027 Channels SHALL be fully independent; simultaneous acceptances on several channels all pulse.

Reset
REQ-028 On n_rst low: sync flops and d_filt = RST_VAL; filter and idle counters = 0; d_rise, d_fall, d_edge, idle, any_edge = 0.
REQ-029 Reset asserted mid-filter SHALL discard any pending transition; first post-reset acceptance requires full REQ-021 latency.

Structure
REQ-030 Shared package edge_pkg SHALL hold the mode typedef enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and default parameter constants.
REQ-031 One sub-module edge_chan (sync chain, filter, pulse logic, idle counter for one channel) SHALL be instantiated NUM_CH times via generate.
REQ-032 Counter widths SHALL be $clog2(FILTER_LEN+1) and $clog2(IDLE_CYCLES+1); no output combinational from d_in.

Verification (defaults, RST_VAL=2'b11)
REQ-033 Reset release, d_in=11 held -> d_filt=11, no pulses; idle[1:0]=11 after edge 8.
REQ-034 mode=11, d_in[0] 1->0 before edge 1 -> d_filt[0]=0, d_fall[0]=1 for one cycle after edge 4; any_edge=1 same cycle; idle[0]=0.
REQ-035 mode=01, d_in[1] low for exactly 1 cycle -> no d_filt change, no pulse; low for 2+ cycles -> d_filt[1]=0, d_fall[1] stays 0, idle[1] clears.
REQ-036 Both channels toggled on the same edge, mode=1111 -> d_edge=11 on the same cycle.
REQ-037 clear asserted while idle=11 -> idle=00 next cycle, d_filt unchanged, idle re-asserts 8 cycles later.
REQ-038 n_rst pulsed 1 cycle after a d_in[0] change -> no pulse; d_filt[0]=1; later change yields pulse at full latency.
